mio_bus_bridge: RTL and testbench
=================================

Name: mio_bus_bridge

Overview:
- Memory/IO bus bridge that sits directly downstream of the multi-cycle CPU.
- Takes the CPU's bus request (CPU_MIO, mem_w, RAMCtrl, Addr_out, Data_out) and decodes it to either the data RAM or the peripheral port.
- Performs byte-lane steering, write-enable generation and load extension.
- Returns Data_in and a single-cycle MIO_ready completion pulse to the CPU.

Parameters:
- RAM_LAT, 1, RAM read latency in cycles (>=1); length of the RAM_WAIT state.
- IO_NIB, 4'hE, addr[31:28] values >= IO_NIB select the IO port; all lower values select RAM.
- IO_TIMEOUT, 16, maximum IO_WAIT cycles without io_ack (used only with MIO_BUS_ERR_EN).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_mio  in  1  CPU bus request; held high with stable addr/wdata/mem_w/ram_ctrl until mio_ready.
- mem_w  in  1  1 = write, 0 = read.
- ram_ctrl  in  3  [1:0] size: 00 byte, 01 half, 10 word, 11 treated as word; [2] 1 = unsigned load.
- addr  in  32  byte address.
- wdata  in  32  store data, right-aligned.
- rdata  out  32  load data to CPU; valid in the mio_ready cycle.
- mio_ready  out  1  one-cycle completion pulse.
- misalign  out  1  one-cycle pulse, coincident with mio_ready, for a misaligned access.
- bus_err  out  1  one-cycle pulse, coincident with mio_ready, for an IO timeout.
- ram_addr  out  30  word address, addr[31:2].
- ram_din  out  32  lane-replicated store data.
- ram_we  out  4  byte write enables.
- ram_dout  in  32  RAM read data.
- io_addr  out  32  latched address.
- io_wdata  out  32  lane-replicated store data.
- io_be  out  4  byte enables.
- io_we  out  1  IO write strobe.
- io_rd  out  1  IO read strobe.
- io_rdata  in  32  IO read data.
- io_ack  in  1  IO completion.

Behaviour:
- FSM states: IDLE, RAM_WAIT, IO_WAIT, DONE.
- Reset: state IDLE. rdata=0; mio_ready, misalign, bus_err, ram_we, io_we, io_rd all 0. Address/data latches cleared to 0.
- IDLE, cpu_mio=1 at edge T:
  - Latch addr, wdata, mem_w, ram_ctrl.
  - Misaligned (word with addr[1:0]!=0, or half with addr[0]!=0): go to DONE. No strobes are issued; rdata=0; misalign pulses with mio_ready at T+1.
  - Otherwise go to IO_WAIT if addr[31:28] >= IO_NIB, else RAM_WAIT.
- Lanes:
  - Byte: be = 4'b0001 << addr[1:0]; data = {4{wdata[7:0]}}.
  - Half: be = 4'b0011 << {addr[1],1'b0}; data = {2{wdata[15:0]}}.
  - Word: be = 4'b1111; data = wdata.
- RAM_WAIT:
  - Lasts exactly RAM_LAT cycles.
  - ram_we = be for the first RAM_WAIT cycle only if mem_w, else 0.
  - On a read, ram_dout is captured in the last RAM_WAIT cycle and extracted to rdata.
  - Then go to DONE; mio_ready is high at T+1+RAM_LAT.
- IO_WAIT:
  - io_we (write) or io_rd (read) is held high with io_be valid until the cycle io_ack=1.
  - On that io_ack cycle, io_rdata is captured (reads) and the FSM goes to DONE.
  - An io_ack seen in IDLE or DONE is ignored.
- Load extraction:
  - Byte: selected lane, sign-extended from bit 7 unless ram_ctrl[2]=1.
  - Half: selected lane, sign-extended from bit 15 unless ram_ctrl[2]=1.
  - Word: passthrough.
- Writes: rdata is unchanged (holds its previous value).
- DONE:
  - mio_ready=1 for exactly one cycle, then go to IDLE.
  - A request still high in the following IDLE cycle is a new access. The CPU must drop cpu_mio or present the next request.
- Reset mid-operation: next edge forces IDLE. All strobes drop that edge; no mio_ready is ever issued for the aborted access.
- cpu_mio falling mid-access: ignored; the access completes normally.

Optional Feature:
- Macro: MIO_BUS_ERR_EN.
- Defined:
  - A cycle counter runs in IO_WAIT.
  - After IO_TIMEOUT cycles without io_ack, the FSM goes to DONE with rdata=32'hDEAD_BEEF (reads) and bus_err pulsing with mio_ready.
  - Strobes drop on the timeout edge.
- Not defined:
  - IO_WAIT waits indefinitely for io_ack.
  - bus_err is tied to 0 and the counter is not built.

Test Plan:
- RAM word write: addr=0x0000_0010, wdata=0x1234_5678, ram_ctrl=010, RAM_LAT=1 → ram_we=4'hF for one cycle, ram_addr=0x4, mio_ready at T+2.
- RAM signed byte load: ram_dout=0x0000_8000, addr=0x...01, ram_ctrl=000 → rdata=0xFFFF_FF80. Same access with ram_ctrl=100 → rdata=0x0000_0080.
- Half store: addr=0x...02, wdata=0xAAAA_BEEF → ram_we=4'b1100, ram_din=0xBEEF_BEEF.
- Misaligned word read: addr=0x...06 → no ram_we/io_rd, mio_ready and misalign together at T+1, rdata=0.
- IO read: addr=0xE000_0000, io_ack asserted 3 cycles after io_rd rises, io_rdata=0x0000_00A5 → rdata=0xA5, mio_ready the cycle after io_ack.
- MIO_BUS_ERR_EN timeout: no io_ack → bus_err and mio_ready after 16 IO_WAIT cycles, rdata=0xDEAD_BEEF.
- Reset mid-operation: reset asserted during RAM_WAIT → state IDLE next edge, no mio_ready pulse.

Source files
------------

// File: rtl/mio_bus_bridge.sv
// Memory/IO bus bridge: decodes CPU bus requests to data RAM or IO port.
// Optional IO timeout with bus_err is built when MIO_BUS_ERR_EN is defined.
module mio_bus_bridge #(
    parameter int          RAM_LAT    = 1,
    parameter logic [3:0]  IO_NIB     = 4'hE,
    parameter int          IO_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_mio,
    input  logic        mem_w,
    input  logic [2:0]  ram_ctrl,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        mio_ready,
    output logic        misalign,
    output logic        bus_err,
    output logic [29:0] ram_addr,
    output logic [31:0] ram_din,
    output logic [3:0]  ram_we,
    input  logic [31:0] ram_dout,
    output logic [31:0] io_addr,
    output logic [31:0] io_wdata,
    output logic [3:0]  io_be,
    output logic        io_we,
    output logic        io_rd,
    input  logic [31:0] io_rdata,
    input  logic        io_ack
);

    typedef enum logic [1:0] {IDLE, RAM_WAIT, IO_WAIT, DONE} state_t;

    state_t      state;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [3:0]  be_q;
    logic        we_q;
    logic [2:0]  ctrl_q;
    logic [7:0]  lat_cnt;

    logic [3:0]  be_n;
    logic [31:0] data_n;
    logic        mis_n;

    assign ram_addr = addr_q[31:2];
    assign ram_din  = data_q;
    assign io_addr  = addr_q;
    assign io_wdata = data_q;
    assign io_be    = be_q;

    always_comb begin
        be_n   = 4'b1111;
        data_n = wdata;
        mis_n  = 1'b0;
        if (ram_ctrl[1]) begin
            mis_n = (addr[1:0] != 2'b00);
        end else if (ram_ctrl[0]) begin
            be_n   = 4'b0011 << {addr[1], 1'b0};
            data_n = {2{wdata[15:0]}};
            mis_n  = addr[0];
        end else begin
            be_n   = 4'b0001 << addr[1:0];
            data_n = {4{wdata[7:0]}};
        end
    end

    // Pick the addressed lane and extend it to 32 bits
    function automatic logic [31:0] load_ext(
        input logic [31:0] d,
        input logic [2:0]  c,
        input logic [1:0]  o
    );
        logic [31:0] b;
        logic [31:0] h;
        b = d >> {o, 3'b000};
        h = d >> {o[1], 4'b0000};
        if (c[1])
            load_ext = d;
        else if (c[0])
            load_ext = c[2] ? {16'h0, h[15:0]} : {{16{h[15]}}, h[15:0]};
        else
            load_ext = c[2] ? {24'h0, b[7:0]} : {{24{b[7]}}, b[7:0]};
    endfunction

`ifdef MIO_BUS_ERR_EN
    logic [15:0] to_cnt;
    logic        err_q;
    assign bus_err = err_q;
`else
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            be_q      <= '0;
            we_q      <= 1'b0;
            ctrl_q    <= '0;
            lat_cnt   <= '0;
            rdata     <= '0;
            mio_ready <= 1'b0;
            misalign  <= 1'b0;
            ram_we    <= '0;
            io_we     <= 1'b0;
            io_rd     <= 1'b0;
`ifdef MIO_BUS_ERR_EN
            to_cnt    <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            mio_ready <= 1'b0;
            misalign  <= 1'b0;
            ram_we    <= '0;
`ifdef MIO_BUS_ERR_EN
            err_q     <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (cpu_mio) begin
                        addr_q <= addr;
                        data_q <= data_n;
                        be_q   <= be_n;
                        we_q   <= mem_w;
                        ctrl_q <= ram_ctrl;
                        if (mis_n) begin
                            state     <= DONE;
                            mio_ready <= 1'b1;
                            misalign  <= 1'b1;
                            rdata     <= '0;
                        end else if (addr[31:28] >= IO_NIB) begin
                            state <= IO_WAIT;
                            io_we <= mem_w;
                            io_rd <= ~mem_w;
`ifdef MIO_BUS_ERR_EN
                            to_cnt <= '0;
`endif
                        end else begin
                            state   <= RAM_WAIT;
                            ram_we  <= mem_w ? be_n : 4'b0000;
                            lat_cnt <= '0;
                        end
                    end
                end
                RAM_WAIT: begin
                    if (lat_cnt == 8'(RAM_LAT - 1)) begin
                        state     <= DONE;
                        mio_ready <= 1'b1;
                        if (!we_q)
                            rdata <= load_ext(ram_dout, ctrl_q, addr_q[1:0]);
                    end else begin
                        lat_cnt <= lat_cnt + 8'd1;
                    end
                end
                IO_WAIT: begin
                    if (io_ack) begin
                        state     <= DONE;
                        mio_ready <= 1'b1;
                        io_we     <= 1'b0;
                        io_rd     <= 1'b0;
                        if (!we_q)
                            rdata <= load_ext(io_rdata, ctrl_q, addr_q[1:0]);
                    end
`ifdef MIO_BUS_ERR_EN
                    else if (to_cnt == 16'(IO_TIMEOUT - 1)) begin
                        state     <= DONE;
                        mio_ready <= 1'b1;
                        err_q     <= 1'b1;
                        io_we     <= 1'b0;
                        io_rd     <= 1'b0;
                        if (!we_q)
                            rdata <= 32'hDEAD_BEEF;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
`endif
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mio_bus_bridge.sv
// Randomized bench for mio_bus_bridge with a transaction-level reference model.
module tb_mio_bus_bridge;

    localparam int LAT = 1;
    localparam int TO  = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_mio;
    logic        mem_w;
    logic [2:0]  ram_ctrl;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        mio_ready;
    logic        misalign;
    logic        bus_err;
    logic [29:0] ram_addr;
    logic [31:0] ram_din;
    logic [3:0]  ram_we;
    logic [31:0] ram_dout;
    logic [31:0] io_addr;
    logic [31:0] io_wdata;
    logic [3:0]  io_be;
    logic        io_we;
    logic        io_rd;
    logic [31:0] io_rdata;
    logic        io_ack;

    mio_bus_bridge #(.RAM_LAT(LAT), .IO_NIB(4'hE), .IO_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .cpu_mio(cpu_mio), .mem_w(mem_w),
        .ram_ctrl(ram_ctrl), .addr(addr), .wdata(wdata), .rdata(rdata),
        .mio_ready(mio_ready), .misalign(misalign), .bus_err(bus_err),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
        .ram_dout(ram_dout), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_be(io_be), .io_we(io_we), .io_rd(io_rd), .io_rdata(io_rdata),
        .io_ack(io_ack)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic        chk_en = 1'b0;
    logic        exp_ready, exp_mis, exp_err, exp_iowe, exp_iord;
    logic [3:0]  exp_rwe, exp_be;
    logic [31:0] exp_data, exp_addr, exp_rdata;
    logic [31:0] model_rdata = 32'h0;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mio_ready", 32'(mio_ready), 32'(exp_ready));
            chk("misalign", 32'(misalign), 32'(exp_mis));
            chk("bus_err", 32'(bus_err), 32'(exp_err));
            chk("ram_we", 32'(ram_we), 32'(exp_rwe));
            chk("io_we", 32'(io_we), 32'(exp_iowe));
            chk("io_rd", 32'(io_rd), 32'(exp_iord));
            if (exp_ready) chk("rdata", rdata, exp_rdata);
            if (exp_rwe != 4'h0) begin
                chk("ram_addr", 32'(ram_addr), 32'(exp_addr[31:2]));
                chk("ram_din", ram_din, exp_data);
            end
            if (exp_iowe || exp_iord) begin
                chk("io_addr", io_addr, exp_addr);
                chk("io_be", 32'(io_be), 32'(exp_be));
                if (exp_iowe) chk("io_wdata", io_wdata, exp_data);
            end
        end
    end

    function automatic logic [31:0] model_load(input logic [2:0] c,
                                               input logic [1:0] off,
                                               input logic [31:0] raw);
        logic [31:0] sh;
        if (c[1]) return raw;
        if (c[0]) begin
            sh = raw >> (16 * int'(off[1]));
            return c[2] ? (sh & 32'hFFFF) : 32'($signed(sh[15:0]));
        end
        sh = raw >> (8 * int'(off));
        return c[2] ? (sh & 32'hFF) : 32'($signed(sh[7:0]));
    endfunction

    task automatic set_idle();
        exp_ready = 0; exp_mis = 0; exp_err = 0;
        exp_rwe = 0; exp_iowe = 0; exp_iord = 0;
    endtask

    // ackd < 0 means the IO side never acknowledges
    task automatic do_access(input logic mw, input logic [2:0] ctrl,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] src, input int ackd,
                             input bit drop_early,
                             output logic [31:0] got_rd,
                             output logic [3:0] got_we,
                             output logic [31:0] got_din,
                             output logic [29:0] got_ra,
                             output int got_c);
        logic [1:0] off;
        logic       word, half, mis, io;
        logic [3:0] be;
        logic [31:0] ld;
        int done_c;
        off  = a[1:0];
        word = ctrl[1];
        half = !ctrl[1] && ctrl[0];
        mis  = (word && off != 0) || (half && off[0]);
        io   = a[31:28] >= 4'hE;
        be   = word ? 4'hF : half ? (4'h3 << (2 * int'(off[1]))) : (4'h1 << off);
        ld   = word ? wd : half ? {2{wd[15:0]}} : {4{wd[7:0]}};
        if (mis) done_c = 1;
        else if (io) done_c = (ackd < 0) ? TO + 1 : ackd + 2;
        else done_c = LAT + 1;
        got_c = -1; got_rd = 0; got_we = 0; got_din = 0; got_ra = 0;

        set_idle();
        exp_addr = a; exp_be = be; exp_data = ld;
        cpu_mio = 1; mem_w = mw; ram_ctrl = ctrl; addr = a; wdata = wd;
        io_ack = 1'($urandom_range(0, 1));
        ram_dout = $urandom; io_rdata = $urandom;
        @(posedge clk); #1;
        for (int c = 1; c <= done_c; c++) begin
            set_idle();
            io_ack = 0;
            ram_dout = $urandom;
            io_rdata = $urandom;
            if (drop_early && c == 1) cpu_mio = 0;
            if (!mis && !io) begin
                if (c == 1 && mw) exp_rwe = be;
                if (c == LAT) ram_dout = src;
            end
            if (!mis && io && c < done_c) begin
                exp_iowe = mw;
                exp_iord = !mw;
                if (c == ackd + 1) begin
                    io_ack = 1;
                    io_rdata = src;
                end
            end
            if (c == 1) begin
                got_we = ram_we; got_din = ram_din; got_ra = ram_addr;
            end
            if (mio_ready && got_c < 0) got_c = c;
            if (c == done_c) begin
                exp_ready = 1;
                exp_mis = mis;
                exp_err = io && !mis && ackd < 0;
                if (mis) model_rdata = 0;
                else if (!mw) model_rdata = exp_err ? 32'hDEAD_BEEF
                                                    : model_load(ctrl, off, src);
                exp_rdata = model_rdata;
                got_rd = rdata;
                cpu_mio = 0;
                io_ack = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
        end
        set_idle();
        io_ack = 0;
    endtask

    logic [31:0] g_rd, g_din;
    logic [3:0]  g_we;
    logic [29:0] g_ra;
    int          g_c;

    initial begin
        reset = 1; cpu_mio = 0; mem_w = 0; ram_ctrl = 0; addr = 0;
        wdata = 0; ram_dout = 0; io_rdata = 0; io_ack = 0;
        set_idle();
        exp_be = 0; exp_data = 0; exp_addr = 0; exp_rdata = 0;
        @(posedge clk); #1;
        chk_en = 1;
        @(posedge clk); @(posedge clk); #1;
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_io_addr", io_addr, 32'h0);
        reset = 0;
        @(posedge clk); #1;

        do_access(1, 3'b010, 32'h10, 32'h1234_5678, 0, 0, 0, g_rd, g_we, g_din, g_ra, g_c);
        chk("word_wr_we", 32'(g_we), 32'hF);
        chk("word_wr_addr", 32'(g_ra), 32'h4);
        chk("word_wr_lat", 32'(g_c), 32'd2);

        do_access(0, 3'b000, 32'h1, 0, 32'h0000_8000, 0, 0, g_rd, g_we, g_din, g_ra, g_c);
        chk("sbyte_ld", g_rd, 32'hFFFF_FF80);
        do_access(0, 3'b100, 32'h1, 0, 32'h0000_8000, 0, 0, g_rd, g_we, g_din, g_ra, g_c);
        chk("ubyte_ld", g_rd, 32'h0000_0080);

        do_access(1, 3'b001, 32'h2, 32'hAAAA_BEEF, 0, 0, 0, g_rd, g_we, g_din, g_ra, g_c);
        chk("half_st_we", 32'(g_we), 32'hC);
        chk("half_st_din", g_din, 32'hBEEF_BEEF);
        chk("wr_holds_rdata", g_rd, 32'h0000_0080);

        do_access(0, 3'b010, 32'h6, 0, 32'h5555_5555, 0, 0, g_rd, g_we, g_din, g_ra, g_c);
        chk("mis_lat", 32'(g_c), 32'd1);
        chk("mis_rdata", g_rd, 32'h0);

        do_access(0, 3'b010, 32'hE000_0000, 0, 32'hA5, 3, 0, g_rd, g_we, g_din, g_ra, g_c);
        chk("io_rd_data", g_rd, 32'hA5);
        chk("io_rd_lat", 32'(g_c), 32'd5);

`ifdef MIO_BUS_ERR_EN
        do_access(0, 3'b010, 32'hF000_0040, 0, 0, -1, 0, g_rd, g_we, g_din, g_ra, g_c);
        chk("to_rdata", g_rd, 32'hDEAD_BEEF);
        chk("to_lat", 32'(g_c), 32'(TO + 1));
`endif

        // Reset while in RAM_WAIT: no completion may follow
        cpu_mio = 1; mem_w = 0; ram_ctrl = 3'b010; addr = 32'h100;
        @(posedge clk); #1;
        reset = 1;
        @(posedge clk); #1;
        reset = 0; cpu_mio = 0;
        model_rdata = 0;
        chk("mid_rst_rdata", rdata, 32'h0);
        repeat (3) @(posedge clk);
        #1;

        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            logic [2:0]  c;
            int          d;
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a[31:28] = 4'hE + 4'($urandom_range(0, 1));
            else if ($urandom_range(0, 1) == 0) a[31:28] = 4'($urandom_range(0, 13));
            c = 3'($urandom_range(0, 7));
            d = $urandom_range(0, 4);
`ifdef MIO_BUS_ERR_EN
            if ($urandom_range(0, 15) == 0) d = -1;
`endif
            do_access(1'($urandom_range(0, 1)), c, a, $urandom, $urandom, d,
                      ($urandom_range(0, 3) == 0), g_rd, g_we, g_din, g_ra, g_c);
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk); #1;
            end
        end

        chk_en = 0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
